vga_timing: RTL and testbench

//   Raster timing generator for the VGA path. Clocked by the divided pixel clock

---
 rtl/vga_pkg.sv | 39 +++
 rtl/vga_timing_if.sv | 22 ++
 rtl/vga_axis_counter.sv | 70 +++++++
 rtl/vga_timing.sv | 138 +++++++++++++
 tb/tb_vga_timing.sv | 162 ++++++++++++++++
 5 files changed

// File: rtl/vga_pkg.sv
// Shared VGA 640x480@60 timing constants, axis region encoding and the
// colour-bar lookup used by the optional test pattern.
package vga_pkg;

    localparam int VGA_H_ACTIVE = 640;
    localparam int VGA_H_FP     = 16;
    localparam int VGA_H_SYNC   = 96;
    localparam int VGA_H_BP     = 48;
    localparam int VGA_V_ACTIVE = 480;
    localparam int VGA_V_FP     = 10;
    localparam int VGA_V_SYNC   = 2;
    localparam int VGA_V_BP     = 33;
    localparam int VGA_CNT_W    = 11;

    typedef enum logic [1:0] {
        REG_ACTIVE = 2'd0,
        REG_FP     = 2'd1,
        REG_SYNC   = 2'd2,
        REG_BP     = 2'd3
    } region_e;

    // Bars run left to right: white, yellow, cyan, green, magenta, red, blue, black.
    function automatic logic [11:0] bar_colour(input logic [2:0] bar);
        logic [11:0] colour;
        case (bar)
            3'd0:    colour = 12'hFFF;
            3'd1:    colour = 12'hFF0;
            3'd2:    colour = 12'h0FF;
            3'd3:    colour = 12'h0F0;
            3'd4:    colour = 12'hF0F;
            3'd5:    colour = 12'hF00;
            3'd6:    colour = 12'h00F;
            3'd7:    colour = 12'h000;
            default: colour = 12'h000;
        endcase
        return colour;
    endfunction

endpackage

// File: rtl/vga_timing_if.sv
// Video output bundle from the raster timing generator to the pixel source / DAC stage.
// The rgb signal exists only when VGA_TEST_PATTERN_EN is defined.
interface vga_timing_if #(
    parameter int CNT_W = 11
);
    logic             hsync;
    logic             vsync;
    logic             de;
    logic [CNT_W-1:0] pixel_x;
    logic [CNT_W-1:0] pixel_y;
    logic             line_start;
    logic             frame_start;
`ifdef VGA_TEST_PATTERN_EN
    logic [11:0]      rgb;

    modport master (output hsync, vsync, de, pixel_x, pixel_y, line_start, frame_start, rgb);
    modport slave  (input  hsync, vsync, de, pixel_x, pixel_y, line_start, frame_start, rgb);
`else
    modport master (output hsync, vsync, de, pixel_x, pixel_y, line_start, frame_start);
    modport slave  (input  hsync, vsync, de, pixel_x, pixel_y, line_start, frame_start);
`endif
endinterface

// File: rtl/vga_axis_counter.sv
// One raster axis: counts 0..TOTAL-1 on inc, reports the region of the count
// and a wrap flag that is high on the inc that returns the count to 0.
module vga_axis_counter
    import vga_pkg::*;
#(
    parameter int ACTIVE = VGA_H_ACTIVE,
    parameter int FP     = VGA_H_FP,
    parameter int SYNC   = VGA_H_SYNC,
    parameter int BP     = VGA_H_BP,
    parameter int CNT_W  = VGA_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    output logic [CNT_W-1:0] count,
    output region_e          region,
    output logic             wrap
);

    localparam int TOTAL = ACTIVE + FP + SYNC + BP;
    localparam logic [CNT_W-1:0] ACT_END  = CNT_W'(ACTIVE);
    localparam logic [CNT_W-1:0] FP_END   = CNT_W'(ACTIVE + FP);
    localparam logic [CNT_W-1:0] SYNC_END = CNT_W'(ACTIVE + FP + SYNC);
    localparam logic [CNT_W-1:0] LAST     = CNT_W'(TOTAL - 1);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // Next count and wrap detection.
    always_comb begin
        wrap    = 1'b0;
        count_d = count_q;
        if (inc) begin
            if (count_q == LAST) begin
                wrap    = 1'b1;
                count_d = {CNT_W{1'b0}};
            end else begin
                count_d = count_q + CNT_W'(1);
            end
        end else begin
            count_d = count_q;
        end
    end

    // Region decode; a zero-width porch simply never matches its window.
    always_comb begin
        region = REG_BP;
        if (count_q < ACT_END) begin
            region = REG_ACTIVE;
        end else if (count_q < FP_END) begin
            region = REG_FP;
        end else if (count_q < SYNC_END) begin
            region = REG_SYNC;
        end else begin
            region = REG_BP;
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= {CNT_W{1'b0}};
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/vga_timing.sv
// Free-running raster timing generator: sync, data-enable, coordinates and
// start pulses, all registered together. Optional colour bars under VGA_TEST_PATTERN_EN.
module vga_timing
    import vga_pkg::*;
#(
    parameter int   H_ACTIVE = VGA_H_ACTIVE,
    parameter int   H_FP     = VGA_H_FP,
    parameter int   H_SYNC   = VGA_H_SYNC,
    parameter int   H_BP     = VGA_H_BP,
    parameter int   V_ACTIVE = VGA_V_ACTIVE,
    parameter int   V_FP     = VGA_V_FP,
    parameter int   V_SYNC   = VGA_V_SYNC,
    parameter int   V_BP     = VGA_V_BP,
    parameter logic HS_POL   = 1'b0,
    parameter logic VS_POL   = 1'b0,
    parameter int   CNT_W    = VGA_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    vga_timing_if.master     vif
);

    // The counters hold the slot presented on the next edge, so the output
    // registers always describe exactly the slot they were decoded from.
    logic [CNT_W-1:0] h_count_s;
    logic [CNT_W-1:0] v_count_s;
    region_e          h_region_s;
    region_e          v_region_s;
    logic             h_wrap_s;
    logic             v_wrap_s;

    vga_axis_counter #(
        .ACTIVE (H_ACTIVE), .FP (H_FP), .SYNC (H_SYNC), .BP (H_BP), .CNT_W (CNT_W)
    ) u_h_axis (
        .clk    (clk),
        .rst_n  (rst_n),
        .inc    (1'b1),
        .count  (h_count_s),
        .region (h_region_s),
        .wrap   (h_wrap_s)
    );

    vga_axis_counter #(
        .ACTIVE (V_ACTIVE), .FP (V_FP), .SYNC (V_SYNC), .BP (V_BP), .CNT_W (CNT_W)
    ) u_v_axis (
        .clk    (clk),
        .rst_n  (rst_n),
        .inc    (h_wrap_s),
        .count  (v_count_s),
        .region (v_region_s),
        .wrap   (v_wrap_s)
    );

    logic             hsync_d, hsync_q;
    logic             vsync_d, vsync_q;
    logic             de_d, de_q;
    logic [CNT_W-1:0] pixel_x_d, pixel_x_q;
    logic [CNT_W-1:0] pixel_y_d, pixel_y_q;
    logic             line_start_d, line_start_q;
    logic             frame_start_d, frame_start_q;

    // Decode the upcoming slot into its output values.
    always_comb begin
        de_d          = (h_region_s == REG_ACTIVE) && (v_region_s == REG_ACTIVE);
        hsync_d       = (h_region_s == REG_SYNC) ? HS_POL : ~HS_POL;
        vsync_d       = (v_region_s == REG_SYNC) ? VS_POL : ~VS_POL;
        line_start_d  = (h_count_s == {CNT_W{1'b0}});
        frame_start_d = (h_count_s == {CNT_W{1'b0}}) && (v_count_s == {CNT_W{1'b0}});
        if (de_d) begin
            pixel_x_d = h_count_s;
            pixel_y_d = v_count_s;
        end else begin
            pixel_x_d = {CNT_W{1'b0}};
            pixel_y_d = {CNT_W{1'b0}};
        end
    end

    // Output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hsync_q       <= ~HS_POL;
            vsync_q       <= ~VS_POL;
            de_q          <= 1'b0;
            pixel_x_q     <= {CNT_W{1'b0}};
            pixel_y_q     <= {CNT_W{1'b0}};
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            de_q          <= de_d;
            pixel_x_q     <= pixel_x_d;
            pixel_y_q     <= pixel_y_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign vif.hsync       = hsync_q;
    assign vif.vsync       = vsync_q;
    assign vif.de          = de_q;
    assign vif.pixel_x     = pixel_x_q;
    assign vif.pixel_y     = pixel_y_q;
    assign vif.line_start  = line_start_q;
    assign vif.frame_start = frame_start_q;

`ifdef VGA_TEST_PATTERN_EN
    localparam int BAR_W = CNT_W + 3;

    logic [BAR_W-1:0] bar_scaled_s;
    logic [11:0]      rgb_d, rgb_q;

    // Bar index is x*8/H_ACTIVE; within the active area it is always 0..7.
    always_comb begin
        bar_scaled_s = {h_count_s, 3'b000} / BAR_W'(H_ACTIVE);
        if (de_d) begin
            rgb_d = bar_colour(bar_scaled_s[2:0]);
        end else begin
            rgb_d = 12'h000;
        end
    end

    // Colour register, aligned with de.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rgb_q <= 12'h000;
        end else begin
            rgb_q <= rgb_d;
        end
    end

    assign vif.rgb = rgb_q;
`endif

    logic unused_s;
    assign unused_s = v_wrap_s;

endmodule

// File: tb/tb_vga_timing.sv
// Directed bench for vga_timing on a small raster (H 8/2/3/3, V 4/1/2/1),
// one instance with active-low syncs and one with active-high syncs.
module tb_vga_timing;

    localparam int CNT_W = 11;

    logic clk;
    logic rst_n;
    int   tests;
    int   fails;

    vga_timing_if #(.CNT_W(CNT_W)) vif0 ();
    vga_timing_if #(.CNT_W(CNT_W)) vif1 ();

    vga_timing #(
        .H_ACTIVE (8), .H_FP (2), .H_SYNC (3), .H_BP (3),
        .V_ACTIVE (4), .V_FP (1), .V_SYNC (2), .V_BP (1),
        .HS_POL (1'b0), .VS_POL (1'b0), .CNT_W (CNT_W)
    ) dut0 (
        .clk   (clk),
        .rst_n (rst_n),
        .vif   (vif0)
    );

    vga_timing #(
        .H_ACTIVE (8), .H_FP (2), .H_SYNC (3), .H_BP (3),
        .V_ACTIVE (4), .V_FP (1), .V_SYNC (2), .V_BP (1),
        .HS_POL (1'b1), .VS_POL (1'b1), .CNT_W (CNT_W)
    ) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .vif   (vif1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int slot, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s slot %0d: observed %0h expected %0h", tag, slot, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset(input int slot);
        chk("rst_de",     slot, 32'(vif0.de), 32'd0);
        chk("rst_hsync",  slot, 32'(vif0.hsync), 32'd1);
        chk("rst_vsync",  slot, 32'(vif0.vsync), 32'd1);
        chk("rst_x",      slot, 32'(vif0.pixel_x), 32'd0);
        chk("rst_y",      slot, 32'(vif0.pixel_y), 32'd0);
        chk("rst_ls",     slot, 32'(vif0.line_start), 32'd0);
        chk("rst_fs",     slot, 32'(vif0.frame_start), 32'd0);
        chk("rst_hs_p1",  slot, 32'(vif1.hsync), 32'd0);
        chk("rst_vs_p1",  slot, 32'(vif1.vsync), 32'd0);
`ifdef VGA_TEST_PATTERN_EN
        chk("rst_rgb",    slot, 32'(vif0.rgb), 32'd0);
`endif
    endtask

    // Expected outputs for slot n counted from a frame start (16 x 8 slots).
    task automatic check_slot(input int n);
        int   h;
        int   v;
        logic e_de;
        logic e_hs;
        logic e_vs;
        logic [11:0] bars [8];
        bars = '{12'hFFF, 12'hFF0, 12'h0FF, 12'h0F0, 12'hF0F, 12'hF00, 12'h00F, 12'h000};
        h    = n % 16;
        v    = (n / 16) % 8;
        e_de = (h < 8) && (v < 4);
        e_hs = (h >= 10) && (h <= 12);
        e_vs = (v >= 5) && (v <= 6);
        chk("de",          n, 32'(vif0.de), 32'(e_de));
        chk("hsync",       n, 32'(vif0.hsync), 32'(!e_hs));
        chk("vsync",       n, 32'(vif0.vsync), 32'(!e_vs));
        chk("pixel_x",     n, 32'(vif0.pixel_x), e_de ? 32'(h) : 32'd0);
        chk("pixel_y",     n, 32'(vif0.pixel_y), e_de ? 32'(v) : 32'd0);
        chk("line_start",  n, 32'(vif0.line_start), 32'(h == 0));
        chk("frame_start", n, 32'(vif0.frame_start), 32'((h == 0) && (v == 0)));
        chk("hsync_pol1",  n, 32'(vif1.hsync), 32'(e_hs));
        chk("vsync_pol1",  n, 32'(vif1.vsync), 32'(e_vs));
        chk("de_pol1",     n, 32'(vif1.de), 32'(e_de));
`ifdef VGA_TEST_PATTERN_EN
        chk("rgb",         n, 32'(vif0.rgb), e_de ? 32'(bars[h % 8]) : 32'd0);
`endif
    endtask

    initial begin
        int de_cnt;
        int vs_low_cnt;
        int last_fs;
        tests      = 0;
        fails      = 0;
        de_cnt     = 0;
        vs_low_cnt = 0;
        last_fs    = -1;
        rst_n      = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset(-1);

        // Release between edges; the next edge presents slot (0,0).
        @(negedge clk);
        rst_n = 1'b1;
        step();
        chk("first_de", 0, 32'(vif0.de), 32'd1);
        chk("first_fs", 0, 32'(vif0.frame_start), 32'd1);
        chk("first_ls", 0, 32'(vif0.line_start), 32'd1);

        // Two full frames plus the start of a third.
        for (int n = 0; n <= 256; n++) begin
            check_slot(n);
            if (n < 128) begin
                if (vif0.de) de_cnt++;
                if (!vif0.vsync) vs_low_cnt++;
            end
            if (vif0.frame_start) begin
                if (last_fs >= 0) chk("fs_period", n, 32'(n - last_fs), 32'd128);
                last_fs = n;
            end
            if (n == 16) chk("line1_y", n, 32'(vif0.pixel_y), 32'd1);
            if (n < 256) step();
        end
        chk("de_per_frame", 128, 32'(de_cnt), 32'd32);
        chk("vs_low_cycles", 128, 32'(vs_low_cnt), 32'd32);

        // Advance into the third frame up to slot h=5, v=3.
        for (int n = 1; n <= 53; n++) begin
            step();
            check_slot(n);
        end
        chk("pre_rst_x", 53, 32'(vif0.pixel_x), 32'd5);
        chk("pre_rst_y", 53, 32'(vif0.pixel_y), 32'd3);

        // Mid-frame reset takes effect without waiting for a clock edge.
        #2;
        rst_n = 1'b0;
        #1;
        check_reset(53);
        repeat (2) @(posedge clk);
        #1;
        check_reset(53);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        for (int n = 0; n < 40; n++) begin
            check_slot(n);
            step();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
